aqe_portb_arb: RTL and testbench

AQE_PORTB_ARB -- requirements
Module: aqe_portb_arb

---
 rtl/aqe_portb_arb.sv | 127 ++++++++++++
 tb/tb_aqe_portb_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aqe_portb_arb.sv
// Two-requester round-robin arbiter for a 128-bit RAM port B. It supports burst ownership,
// a forced release after MAX_BURST beats, and an in-order read-return pipe.
module aqe_portb_arb #(
    parameter int ADDR_W    = 20,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    input  logic              req0,
    input  logic              req1,
    input  logic              last0,
    input  logic              last1,
    input  logic [15:0]       wen0,
    input  logic [15:0]       wen1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [127:0]      wdata0,
    input  logic [127:0]      wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [127:0]      rdata,
    output logic [15:0]       portb_wen,
    output logic [ADDR_W-1:0] portb_addr,
    output logic [127:0]      portb_din,
    input  logic [127:0]      portb_dout
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t            r_state;
    logic              r_rr_ptr;
    logic [7:0]        r_beat_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [127:0]      r_din;
    logic [RD_LAT-1:0] r_rd_vld_p;
    logic [RD_LAT-1:0] r_rd_id_p;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_win;
    logic              w_acc;
    logic              w_last;
    logic              w_done;
    logic              w_is_rd;
    logic [15:0]       w_wen;
    logic [ADDR_W-1:0] w_addr;
    logic [127:0]      w_din;
    logic [7:0]        w_cnt_nxt;

    // An owner keeps its grant even while its request is low, which parks the port.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            OWN0:    w_gnt0 = 1'b1;
            OWN1:    w_gnt1 = 1'b1;
            default: begin
                if (req0 && req1) begin
                    w_gnt0 = ~r_rr_ptr;
                    w_gnt1 = r_rr_ptr;
                end else begin
                    w_gnt0 = req0;
                    w_gnt1 = req1;
                end
            end
        endcase
    end

    assign w_win     = w_gnt1;
    assign w_acc     = (w_gnt0 & req0) | (w_gnt1 & req1);
    assign w_wen     = w_win ? wen1   : wen0;
    assign w_addr    = w_win ? addr1  : addr0;
    assign w_din     = w_win ? wdata1 : wdata0;
    assign w_last    = w_win ? last1  : last0;
    assign w_cnt_nxt = r_beat_cnt + 8'd1;
    assign w_done    = w_last | (w_cnt_nxt == 8'(MAX_BURST));
    assign w_is_rd   = w_acc & (w_wen == 16'd0);

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= 8'd0;
            r_addr     <= '0;
            r_din      <= '0;
        end else if (w_acc) begin
            r_addr <= w_addr;
            r_din  <= w_din;
            if (w_done) begin
                r_state    <= IDLE;
                r_beat_cnt <= 8'd0;
                r_rr_ptr   <= ~w_win;
            end else begin
                r_state    <= w_win ? OWN1 : OWN0;
                r_beat_cnt <= w_cnt_nxt;
            end
        end
    end

    // Read-return pipe: stage 0 holds the beat issued on the previous cycle.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_rd_vld_p <= '0;
            r_rd_id_p  <= '0;
        end else begin
            r_rd_vld_p[0] <= w_is_rd;
            r_rd_id_p[0]  <= w_win;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_vld_p[i] <= r_rd_vld_p[i-1];
                r_rd_id_p[i]  <= r_rd_id_p[i-1];
            end
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign rvalid0    = r_rd_vld_p[RD_LAT-1] & ~r_rd_id_p[RD_LAT-1];
    assign rvalid1    = r_rd_vld_p[RD_LAT-1] &  r_rd_id_p[RD_LAT-1];
    assign rdata      = portb_dout;
    assign portb_wen  = w_acc ? w_wen  : 16'd0;
    assign portb_addr = w_acc ? w_addr : r_addr;
    assign portb_din  = w_acc ? w_din  : r_din;

endmodule

// File: tb/tb_aqe_portb_arb.sv
// Scoreboard bench for aqe_portb_arb: a reference model predicts each cycle's grant and port values
// and the queued read returns, and a separate monitor compares the DUT against those predictions.
module tb_aqe_portb_arb;
    localparam int ADDR_W    = 20;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 16;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
    logic [15:0]       wen0 = '0, wen1 = '0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [127:0]      wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [127:0]      rdata;
    logic [15:0]       portb_wen;
    logic [ADDR_W-1:0] portb_addr;
    logic [127:0]      portb_din;
    logic [127:0]      portb_dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aqe_portb_arb #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b),
        .req0(req0), .req1(req1), .last0(last0), .last1(last1),
        .wen0(wen0), .wen1(wen1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .portb_wen(portb_wen), .portb_addr(portb_addr),
        .portb_din(portb_din), .portb_dout(portb_dout)
    );

    // RAM behind port B: 16 words, RD_LAT-cycle read, byte-enabled write
    logic [127:0] ram [16];
    logic [127:0] dpipe [RD_LAT];
    assign portb_dout = dpipe[RD_LAT-1];

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = '0;
        for (int i = 0; i < RD_LAT; i++) dpipe[i] = '0;
    end

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
        dpipe[0] <= ram[portb_addr[3:0]];
        for (int b = 0; b < 16; b++)
            if (portb_wen[b]) ram[portb_addr[3:0]][b*8 +: 8] <= portb_din[b*8 +: 8];
    end

    // Reference model
    typedef struct {
        bit                g0;
        bit                g1;
        logic [15:0]       wen;
        logic [ADDR_W-1:0] addr;
        logic [127:0]      din;
    } exp_t;

    typedef struct {
        bit           id;
        int           due;
        logic [127:0] data;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];

    int                m_owner = -1;
    int                m_beats = 0;
    bit                m_rr = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [127:0]      m_din = '0;
    logic [127:0]      m_mem [16];

    initial for (int i = 0; i < 16; i++) m_mem[i] = '0;

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_rr    = 1'b0;
        m_addr  = '0;
        m_din   = '0;
        rd_q.delete();
    endtask

    task automatic model_step();
        exp_t              e;
        rd_t               r;
        int                win;
        bit                acc;
        bit                lst;
        logic [15:0]       w;
        logic [ADDR_W-1:0] a;
        logic [127:0]      d;
        win = -1;
        if (m_owner >= 0)       win = m_owner;
        else if (req0 && req1)  win = m_rr ? 1 : 0;
        else if (req0)          win = 0;
        else if (req1)          win = 1;
        acc    = (win == 0 && req0) || (win == 1 && req1);
        e.g0   = (win == 0);
        e.g1   = (win == 1);
        e.wen  = 16'd0;
        e.addr = m_addr;
        e.din  = m_din;
        if (acc) begin
            w   = (win == 1) ? wen1   : wen0;
            a   = (win == 1) ? addr1  : addr0;
            d   = (win == 1) ? wdata1 : wdata0;
            lst = (win == 1) ? last1  : last0;
            e.wen  = w;
            e.addr = a;
            e.din  = d;
            m_addr = a;
            m_din  = d;
            if (w == 16'd0) begin
                r.id   = (win == 1);
                r.due  = cyc + RD_LAT;
                r.data = m_mem[a[3:0]];
                rd_q.push_back(r);
            end else begin
                for (int b = 0; b < 16; b++)
                    if (w[b]) m_mem[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
            end
            m_beats++;
            if (lst || m_beats == MAX_BURST) begin
                m_owner = -1;
                m_beats = 0;
                m_rr    = (win == 0);
            end else begin
                m_owner = win;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
        end
    endtask

    // Monitor: compares DUT outputs against predictions, mid-cycle
    initial begin
        exp_t e;
        rd_t  r;
        forever begin
            @(posedge clk);
            #6;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", 128'({gnt0, gnt1}), 128'({e.g0, e.g1}));
                chk("portb_wen", 128'(portb_wen), 128'(e.wen));
                chk("portb_addr", 128'(portb_addr), 128'(e.addr));
                chk("portb_din", portb_din, e.din);
                if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                    r = rd_q.pop_front();
                    chk("rvalid", 128'({rvalid0, rvalid1}), 128'({!r.id, r.id}));
                    chk("rdata", rdata, r.data);
                end else begin
                    chk("rvalid_idle", 128'({rvalid0, rvalid1}), 128'(2'b00));
                end
            end
        end
    end

    // Stimulus
    task automatic drive(input bit r0, input bit l0, input logic [15:0] w0, input int a0,
                         input bit r1, input bit l1, input logic [15:0] w1, input int a1);
        rst_b  = 1'b1;
        req0   = r0;
        last0  = l0;
        wen0   = w0;
        addr0  = ADDR_W'(a0);
        wdata0 = {$urandom, $urandom, $urandom, $urandom};
        req1   = r1;
        last1  = l1;
        wen1   = w1;
        addr1  = ADDR_W'(a1);
        wdata1 = {$urandom, $urandom, $urandom, $urandom};
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle();
        rst_b = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        model_reset();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_wen();
        return ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom);
    endfunction

    initial begin
        @(posedge clk);
        #1;
        rst_cycle();
        rst_cycle();

        // Alternation with both requesting single-beat bursts
        for (int i = 0; i < 4; i++) drive(1, 1, 16'd0, 1, 1, 1, 16'd0, 2);

        // Requester 0 four-beat read burst while requester 1 waits
        for (int i = 0; i < 4; i++) drive(1, i == 3, 16'd0, 'h10 + i, 1, 1, 16'd0, 5);
        drive(0, 0, 16'd0, 0, 1, 1, 16'd0, 5);

        // Streaming without last: forced release after MAX_BURST beats
        for (int i = 0; i < 20; i++) drive(1, 0, 16'd0, i % 16, 1, 1, 16'hFFFF, 7);
        drive(1, 1, 16'd0, 2, 0, 0, 16'd0, 0);

        // Single write beat
        drive(1, 1, 16'h000F, 5, 0, 0, 16'd0, 0);
        drive(1, 1, 16'd0, 5, 0, 0, 16'd0, 0);

        // Owner 1 stalls for three cycles while requester 0 waits
        drive(0, 0, 16'd0, 0, 1, 0, 16'hFFFF, 3);
        for (int i = 0; i < 3; i++) drive(1, 1, 16'h00FF, 4, 0, 0, 16'd0, 0);
        drive(1, 1, 16'h00FF, 4, 1, 0, 16'd0, 3);
        drive(1, 1, 16'h00FF, 4, 1, 1, 16'd0, 4);
        drive(1, 1, 16'd0, 4, 0, 0, 16'd0, 0);

        // Read from requester 1 abandoned by a reset pulse
        drive(0, 0, 16'd0, 0, 1, 1, 16'd0, 3);
        rst_cycle();
        rst_cycle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) rst_cycle();
            else drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, rnd_wen(), $urandom_range(0, 15),
                       $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, rnd_wen(), $urandom_range(0, 15));
        end

        for (int i = 0; i < RD_LAT + 3; i++) drive(0, 0, 16'd0, 0, 0, 0, 16'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
